// File: rtl/crc_frame_tx.sv
// crc_frame_tx: computes a serial CRC over a latched payload, then streams {payload, crc} MSB first
// with ready/valid flow control on the bit output.
module crc_frame_tx #(
  parameter int                   DATA_WIDTH        = 12,
  parameter int                   CRC_WIDTH         = 4,
  parameter logic [CRC_WIDTH:0]   POLY              = 5'b10011,
  parameter logic [CRC_WIDTH-1:0] SEED              = '0,
  parameter int                   XOR_OPS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  tx_bit,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_sof,
  output logic                  tx_eof,
  output logic [CRC_WIDTH-1:0]  crc_out,
  output logic                  frame_done
);
  localparam int FW     = DATA_WIDTH + CRC_WIDTH;
  localparam int CNT_W  = $clog2(DATA_WIDTH + 1) + 1;
  localparam int SCNT_W = $clog2(FW);
  if (XOR_OPS_PER_CYCLE < 1 || XOR_OPS_PER_CYCLE > DATA_WIDTH) begin : g_bad_ops
    $error("crc_frame_tx: XOR_OPS_PER_CYCLE must be in 1..DATA_WIDTH");
  end
  typedef enum logic [1:0] {S_IDLE, S_CRC_CALC, S_SEND, S_DONE} state_t;
  state_t                state;
  logic [CRC_WIDTH-1:0]  crc, crc_nx;
  logic [DATA_WIDTH-1:0] shift_reg, sh_nx;
  logic [FW-1:0]         frame_reg;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  logic [SCNT_W-1:0]     scnt;
  logic                  fb;
  assign in_ready = state == S_IDLE;
  // Bits past the end of the payload are skipped so the counter never underflows.
  always_comb begin
    crc_nx = crc;
    sh_nx  = shift_reg;
    cnt_nx = cnt;
    fb     = 1'b0;
    for (int i = 0; i < XOR_OPS_PER_CYCLE; i++) begin
      if (cnt_nx != '0) begin
        fb     = sh_nx[DATA_WIDTH-1] ^ crc_nx[CRC_WIDTH-1];
        crc_nx = (crc_nx << 1) ^ (fb ? POLY[CRC_WIDTH-1:0] : '0);
        sh_nx  = sh_nx << 1;
        cnt_nx = cnt_nx - 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      crc        <= SEED;
      shift_reg  <= '0;
      frame_reg  <= '0;
      cnt        <= '0;
      scnt       <= '0;
      crc_out    <= '0;
      tx_valid   <= 1'b0;
      tx_sof     <= 1'b0;
      tx_eof     <= 1'b0;
      tx_bit     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          shift_reg <= in_data;
          frame_reg <= {in_data, {CRC_WIDTH{1'b0}}};
          crc       <= SEED;
          cnt       <= CNT_W'(DATA_WIDTH);
          state     <= S_CRC_CALC;
        end
        S_CRC_CALC: begin
          crc       <= crc_nx;
          shift_reg <= sh_nx;
          cnt       <= cnt_nx;
          if (cnt_nx == '0) begin
            frame_reg <= {frame_reg[FW-1:CRC_WIDTH], crc_nx};
            crc_out   <= crc_nx;
            tx_valid  <= 1'b1;
            tx_sof    <= 1'b1;
            tx_eof    <= 1'b0;
            tx_bit    <= frame_reg[FW-1];
            scnt      <= SCNT_W'(FW - 1);
            state     <= S_SEND;
          end
        end
        S_SEND: if (tx_ready) begin
          if (scnt == '0) begin
            tx_valid   <= 1'b0;
            tx_sof     <= 1'b0;
            tx_eof     <= 1'b0;
            tx_bit     <= 1'b0;
            frame_done <= 1'b1;
            state      <= S_DONE;
          end else begin
            frame_reg <= frame_reg << 1;
            tx_bit    <= frame_reg[FW-2];
            tx_sof    <= 1'b0;
            tx_eof    <= scnt == SCNT_W'(1);
            scnt      <= scnt - 1'b1;
          end
        end
        default: begin
          frame_done <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_crc_frame_tx.sv
// tb_crc_frame_tx: directed checks of framing, CRC values, latency, flow control and reset.
module tb_crc_frame_tx;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, iv_x = 1'b0, tx_ready = 1'b1;
  logic [11:0] in_data = '0;
  logic        in_ready, tx_bit, tx_valid, tx_sof, tx_eof, frame_done;
  logic [3:0]  crc_out;
  logic        r4, b4, v4, s4, e4, d4, r5, b5, v5, s5, e5, d5;
  logic [3:0]  c4, c5;
  int          checks = 0, errors = 0;
  logic [15:0] s_bits, sof_bits, eof_bits;
  int          t_valid, t_done, t4, t5, viol, hold_err, nbits;

  crc_frame_tx u_dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .tx_bit(tx_bit), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_sof(tx_sof), .tx_eof(tx_eof), .crc_out(crc_out), .frame_done(frame_done));
  crc_frame_tx #(.XOR_OPS_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .in_valid(iv_x),
    .in_ready(r4), .in_data(in_data), .tx_bit(b4), .tx_valid(v4), .tx_ready(tx_ready),
    .tx_sof(s4), .tx_eof(e4), .crc_out(c4), .frame_done(d4));
  crc_frame_tx #(.XOR_OPS_PER_CYCLE(5)) u_dut5 (.clk(clk), .rst_n(rst_n), .in_valid(iv_x),
    .in_ready(r5), .in_data(in_data), .tx_bit(b5), .tx_valid(v5), .tx_ready(tx_ready),
    .tx_sof(s5), .tx_eof(e5), .crc_out(c5), .frame_done(d5));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic start(input logic [11:0] d, input logic x, input logic keep);
    in_valid = 1'b1;
    iv_x     = x;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = keep;
    iv_x     = 1'b0;
  endtask

  // Cycle k=1 is the first cycle after the accept edge.
  task automatic recv(input logic throttle, input logic chg, input int stop_bit);
    logic       held = 1'b0;
    logic [2:0] pv = '0;
    s_bits = '0; sof_bits = '0; eof_bits = '0;
    t_valid = 0; t_done = 0; t4 = 0; t5 = 0; viol = 0; hold_err = 0; nbits = 0;
    for (int k = 1; k < 400; k++) begin
      if (!tx_valid && (tx_bit || tx_sof || tx_eof)) viol++;
      if (v4 && t4 == 0) t4 = k;
      if (v5 && t5 == 0) t5 = k;
      if (tx_valid && t_valid == 0) t_valid = k;
      if (held && {tx_bit, tx_sof, tx_eof} !== pv) hold_err++;
      if (frame_done) begin
        t_done = k;
        in_valid = 1'b0;
        break;
      end
      if (stop_bit >= 0 && nbits == stop_bit && tx_valid) return;
      tx_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      if (chg) in_data = 12'($urandom);
      if (tx_valid && tx_ready) begin
        s_bits   = {s_bits[14:0], tx_bit};
        sof_bits = {sof_bits[14:0], tx_sof};
        eof_bits = {eof_bits[14:0], tx_eof};
        nbits++;
      end
      held = tx_valid && !tx_ready;
      pv   = {tx_bit, tx_sof, tx_eof};
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    tx_ready = 1'b1;
  endtask

  initial begin
    #2;
    chk("rst_outputs", {tx_valid, tx_bit, tx_sof, tx_eof, frame_done, crc_out}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1);

    start(12'hABC, 1'b1, 1'b0);
    recv(1'b0, 1'b0, -1);
    chk("abc_first_valid", t_valid, 13);
    chk("abc_stream", s_bits, 16'hABCA);
    chk("abc_crc", crc_out, 4'hA);
    chk("abc_sof", sof_bits, 16'h8000);
    chk("abc_eof", eof_bits, 16'h0001);
    chk("abc_done", t_done, 29);
    chk("abc_idle_zero", viol, 0);
    chk("done_not_ready", in_ready, 0);
    chk("ops4_latency", t4, 4);
    chk("ops5_latency", t5, 4);
    chk("ops4_crc", c4, 4'hA);
    chk("ops5_crc", c5, 4'hA);
    @(posedge clk); #1;
    chk("ready_after_done", in_ready, 1);
    chk("done_one_cycle", frame_done, 0);

    start(12'h000, 1'b0, 1'b0);
    chk("crc_out_held", crc_out, 4'hA);
    recv(1'b0, 1'b0, -1);
    chk("zero_stream", s_bits, 16'h0000);
    chk("zero_crc", crc_out, 4'h0);
    @(posedge clk); #1;

    start(12'h001, 1'b0, 1'b0);
    recv(1'b0, 1'b0, -1);
    chk("one_stream", s_bits, 16'h0013);
    chk("one_crc", crc_out, 4'h3);
    @(posedge clk); #1;

    start(12'hABC, 1'b0, 1'b0);
    recv(1'b1, 1'b0, -1);
    chk("thr_stream", s_bits, 16'hABCA);
    chk("thr_hold", hold_err, 0);
    chk("thr_sof", sof_bits, 16'h8000);
    chk("thr_eof", eof_bits, 16'h0001);
    chk("thr_crc", crc_out, 4'hA);
    @(posedge clk); #1;

    start(12'h001, 1'b0, 1'b1);
    recv(1'b0, 1'b1, -1);
    chk("chg_stream", s_bits, 16'h0013);
    chk("chg_crc", crc_out, 4'h3);
    @(posedge clk); #1;

    start(12'hABC, 1'b0, 1'b0);
    recv(1'b0, 1'b0, 7);
    chk("bit7_present", {tx_valid, tx_bit}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {tx_valid, tx_bit, tx_sof, tx_eof, frame_done, crc_out}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_in_ready", in_ready, 1);
    start(12'hABC, 1'b0, 1'b0);
    recv(1'b0, 1'b0, -1);
    chk("post_rst_stream", s_bits, 16'hABCA);
    chk("post_rst_crc", crc_out, 4'hA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
